// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: data width, counter CSR addresses and
// the address/word types used across the pipeline.
package rv_core_pkg;

    localparam int XLEN = 32;
    localparam int NCSR = 64;

    typedef logic [4:0]      reg_addr_t;
    typedef logic [5:0]      csr_addr_t;
    typedef logic [XLEN-1:0] word_t;

    localparam csr_addr_t CSR_CYCLE   = 6'h3E;
    localparam csr_addr_t CSR_INSTRET = 6'h3F;

endpackage

// File: rtl/csr_counter.sv
// Free-running CSR counter. A load takes priority over an increment
// in the same cycle, and the count wraps modulo 2^W.
module csr_counter
    import rv_core_pkg::*;
#(
    parameter int W = rv_core_pkg::XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_data;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/regfile_csr_sink.sv
// Writeback sink: 32x32 GPR file and 64-entry CSR bank with cycle/instret
// counters, committing on each edge and serving bypassed combinational reads.
module regfile_csr_sink
    import rv_core_pkg::*;
#(
    parameter int        XLEN        = rv_core_pkg::XLEN,
    parameter int        NCSR        = rv_core_pkg::NCSR,
    parameter csr_addr_t CSR_CYCLE   = rv_core_pkg::CSR_CYCLE,
    parameter csr_addr_t CSR_INSTRET = rv_core_pkg::CSR_INSTRET
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            regWrite_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] data_i,
    input  logic            csrWrite_i,
    input  logic [5:0]      csr_Addr_i,
    input  logic [XLEN-1:0] csrData_i,
    input  logic            retire_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic [5:0]      csr_raddr_i,
    output logic [XLEN-1:0] csr_rdata_o
);

    logic [XLEN-1:0] gpr [32];
    logic [XLEN-1:0] csr_q [NCSR];
    logic [XLEN-1:0] cycle_count;
    logic [XLEN-1:0] instret_count;

    logic      gpr_we;
    logic      load_cycle;
    logic      load_instret;
    logic      csr_bank_we;
    reg_addr_t rs1_a;
    reg_addr_t rs2_a;
    csr_addr_t csr_ra;

    assign gpr_we       = regWrite_i && (rd_i != 5'd0);
    assign load_cycle   = csrWrite_i && (csr_Addr_i == CSR_CYCLE);
    assign load_instret = csrWrite_i && (csr_Addr_i == CSR_INSTRET);
    assign csr_bank_we  = csrWrite_i && !load_cycle && !load_instret;
    assign rs1_a        = rs1_i;
    assign rs2_a        = rs2_i;
    assign csr_ra       = csr_raddr_i;

    // x0 is never written, so its flop stays at its reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (gpr_we) begin
            gpr[rd_i] <= data_i;
        end
    end

    // Counter addresses are owned by the counter instances, not the bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCSR; i++) begin
                csr_q[i] <= '0;
            end
        end else if (csr_bank_we) begin
            csr_q[csr_Addr_i] <= csrData_i;
        end
    end

    csr_counter #(.W(XLEN)) u_cycle (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (1'b1),
        .load      (load_cycle),
        .load_data (csrData_i),
        .count     (cycle_count)
    );

    csr_counter #(.W(XLEN)) u_instret (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (retire_i),
        .load      (load_instret),
        .load_data (csrData_i),
        .count     (instret_count)
    );

    always_comb begin
        rdata1_o = (rs1_a == 5'd0) ? '0 : gpr[rs1_a];
        if (gpr_we && (rs1_a == rd_i)) begin
            rdata1_o = data_i;
        end
    end

    always_comb begin
        rdata2_o = (rs2_a == 5'd0) ? '0 : gpr[rs2_a];
        if (gpr_we && (rs2_a == rd_i)) begin
            rdata2_o = data_i;
        end
    end

    // Bypass is independent of reset so in-flight write data still shows
    always_comb begin
        if (csr_ra == CSR_CYCLE) begin
            csr_rdata_o = cycle_count;
        end else if (csr_ra == CSR_INSTRET) begin
            csr_rdata_o = instret_count;
        end else begin
            csr_rdata_o = csr_q[csr_ra];
        end
        if (csrWrite_i && (csr_ra == csr_Addr_i)) begin
            csr_rdata_o = csrData_i;
        end
    end

endmodule

// File: tb/tb_regfile_csr_sink.sv
// Scoreboard bench for regfile_csr_sink: a behavioural model predicts each
// cycle's read data, and a negedge monitor compares the DUT against it.
module tb_regfile_csr_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        regWrite_i = 1'b0;
    logic [4:0]  rd_i = '0;
    logic [31:0] data_i = '0;
    logic        csrWrite_i = 1'b0;
    logic [5:0]  csr_Addr_i = '0;
    logic [31:0] csrData_i = '0;
    logic        retire_i = 1'b0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [31:0] rdata1_o;
    logic [31:0] rdata2_o;
    logic [5:0]  csr_raddr_i = '0;
    logic [31:0] csr_rdata_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit        rst_n;
        bit        rw;
        bit [4:0]  rd;
        bit [31:0] d;
        bit        cw;
        bit [5:0]  ca;
        bit [31:0] cd;
        bit        ret;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit [5:0]  cr;
    } stim_t;

    typedef struct {
        string     name;
        bit [31:0] r1;
        bit [31:0] r2;
        bit [31:0] c;
    } exp_t;

    exp_t exp_q[$];

    // Architectural reference state
    bit [31:0] m_gpr [32];
    bit [31:0] m_csr [64];
    bit [31:0] m_cycle;
    bit [31:0] m_instret;

    regfile_csr_sink dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .regWrite_i  (regWrite_i),
        .rd_i        (rd_i),
        .data_i      (data_i),
        .csrWrite_i  (csrWrite_i),
        .csr_Addr_i  (csr_Addr_i),
        .csrData_i   (csrData_i),
        .retire_i    (retire_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .rdata1_o    (rdata1_o),
        .rdata2_o    (rdata2_o),
        .csr_raddr_i (csr_raddr_i),
        .csr_rdata_o (csr_rdata_o)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.rw = 1'b0; s.rd = '0; s.d = '0;
        s.cw = 1'b0; s.ca = '0; s.cd = '0; s.ret = 1'b0;
        s.rs1 = '0; s.rs2 = '0; s.cr = '0;
        return s;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        for (int i = 0; i < 64; i++) m_csr[i] = '0;
        m_cycle = '0;
        m_instret = '0;
    endfunction

    function automatic bit [31:0] m_gpr_read(bit [4:0] rs, stim_t s);
        if (s.rw && s.rd != 0 && rs == s.rd) return s.d;
        if (rs == 0) return '0;
        return m_gpr[rs];
    endfunction

    function automatic bit [31:0] m_csr_read(bit [5:0] a, stim_t s);
        if (s.cw && a == s.ca) return s.cd;
        if (a == 6'h3E) return m_cycle;
        if (a == 6'h3F) return m_instret;
        return m_csr[a];
    endfunction

    function automatic void m_commit(stim_t s);
        if (!s.rst_n) return;
        if (s.rw && s.rd != 0) m_gpr[s.rd] = s.d;
        if (s.cw && s.ca == 6'h3E) m_cycle = s.cd;
        else m_cycle = m_cycle + 32'd1;
        if (s.cw && s.ca == 6'h3F) m_instret = s.cd;
        else if (s.ret) m_instret = m_instret + 32'd1;
        if (s.cw && s.ca != 6'h3E && s.ca != 6'h3F) m_csr[s.ca] = s.cd;
    endfunction

    // Called just after a rising edge; holds the inputs for one full cycle
    task automatic apply_stimulus(input stim_t s, input string name);
        exp_t e;
        rst_n       = s.rst_n;
        regWrite_i  = s.rw;
        rd_i        = s.rd;
        data_i      = s.d;
        csrWrite_i  = s.cw;
        csr_Addr_i  = s.ca;
        csrData_i   = s.cd;
        retire_i    = s.ret;
        rs1_i       = s.rs1;
        rs2_i       = s.rs2;
        csr_raddr_i = s.cr;
        if (!s.rst_n) m_reset();
        e.name = name;
        e.r1 = m_gpr_read(s.rs1, s);
        e.r2 = m_gpr_read(s.rs2, s);
        e.c  = m_csr_read(s.cr, s);
        exp_q.push_back(e);
        @(posedge clk);
        m_commit(s);
        #1;
    endtask

    task automatic check_output(input string name, input string field,
                                input logic [31:0] act, input bit [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e.name, "rdata1", rdata1_o, e.r1);
            check_output(e.name, "rdata2", rdata2_o, e.r2);
            check_output(e.name, "csr_rdata", csr_rdata_o, e.c);
        end
    end

    initial begin
        stim_t s;
        bit [2:0] ret_pat [5];
        ret_pat[0] = 1; ret_pat[1] = 1; ret_pat[2] = 0; ret_pat[3] = 1; ret_pat[4] = 0;
        m_reset();
        @(posedge clk); #1;

        s = idle(); s.rst_n = 0;                        apply_stimulus(s, "reset");
        s = idle(); s.rs1 = 5; s.rs2 = 31; s.cr = 6'h10; apply_stimulus(s, "rst_read");
        s = idle(); s.cr = 6'h3E;                       apply_stimulus(s, "cycle_one");

        s = idle(); s.rw = 1; s.rd = 7; s.d = 32'hDEAD_BEEF; s.rs2 = 7;
        apply_stimulus(s, "x7_bypass");
        s = idle(); s.rs1 = 7;                          apply_stimulus(s, "x7_read");

        s = idle(); s.rw = 1; s.rd = 0; s.d = 32'h1234; apply_stimulus(s, "x0_same");
        s = idle();                                     apply_stimulus(s, "x0_next");

        s = idle(); s.rw = 1; s.rd = 3; s.d = 32'hA; s.cw = 1; s.ca = 6'h05; s.cd = 32'hB;
        apply_stimulus(s, "csrrw_wr");
        s = idle(); s.rs1 = 3; s.cr = 6'h05;            apply_stimulus(s, "csrrw_rd");

        s = idle(); s.rst_n = 0;                        apply_stimulus(s, "ctr_reset");
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.ret = ret_pat[i][0];          apply_stimulus(s, "ctr_pulse");
        end
        s = idle(); s.cr = 6'h3E;                       apply_stimulus(s, "cycle5");
        s = idle(); s.cr = 6'h3F;                       apply_stimulus(s, "instret3");

        s = idle(); s.cw = 1; s.ca = 6'h3F; s.cd = 32'hFFFF_FFFF; s.ret = 1; s.cr = 6'h3F;
        apply_stimulus(s, "instret_ld");
        s = idle(); s.ret = 1; s.cr = 6'h3F;            apply_stimulus(s, "instret_max");
        s = idle(); s.cr = 6'h3F;                       apply_stimulus(s, "instret_wrap");

        s = idle(); s.rw = 1; s.rd = 9; s.d = 32'd7; s.cw = 1; s.ca = 6'h3E; s.cd = 32'd100;
        apply_stimulus(s, "preload");
        s = idle(); s.rs1 = 9; s.cr = 6'h3E;            apply_stimulus(s, "preload_rd");
        s = idle(); s.rst_n = 0; s.rs1 = 9; s.cr = 6'h3E;
        apply_stimulus(s, "async_rst");
        s = idle(); s.rs1 = 9; s.cr = 6'h3E;            apply_stimulus(s, "post_rst");

        for (int i = 0; i < 400; i++) begin
            int sel;
            s = idle();
            s.rst_n = ($urandom_range(0, 63) != 0);
            s.rw  = 1'($urandom_range(0, 1));
            s.rd  = 5'($urandom_range(0, 7));
            s.d   = $urandom;
            s.cw  = 1'($urandom_range(0, 1));
            sel   = $urandom_range(0, 5);
            s.ca  = (sel == 4) ? 6'h3E : (sel == 5) ? 6'h3F : 6'(sel);
            s.cd  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            s.ret = 1'($urandom_range(0, 1));
            s.rs1 = ($urandom_range(0, 2) == 0) ? s.rd : 5'($urandom_range(0, 7));
            s.rs2 = ($urandom_range(0, 2) == 0) ? s.rd : 5'($urandom_range(0, 7));
            sel   = $urandom_range(0, 5);
            s.cr  = (sel == 4) ? 6'h3E : (sel == 5) ? 6'h3F : 6'(sel);
            if ($urandom_range(0, 2) == 0) s.cr = s.ca;
            apply_stimulus(s, "random");
        end

        s = idle(); apply_stimulus(s, "final");
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
